// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between four requesters.
// Issues one access at a time; all outputs are registered.
module data_mem_arbiter #(
  parameter int unsigned WIDTH     = 15,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MEM_DEPTH = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               req,
  input  logic [3:0]               we,
  input  logic [4*ADDR_W-1:0]      addr,
  input  logic [4*(WIDTH+1)-1:0]   wdata,
  output logic [3:0]               gnt,
  output logic [3:0]               rvalid,
  output logic [WIDTH:0]           rdata,
  output logic [3:0]               err,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [WIDTH:0]           mem_wdata,
  input  logic [WIDTH:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          win_q, win_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          rvalid_q, rvalid_d;
  logic [3:0]          err_q, err_d;
  logic                busy_q, busy_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH:0]      mem_wdata_q, mem_wdata_d;
  logic [WIDTH:0]      rdata_q, rdata_d;

  logic [1:0]          pick;
  logic [1:0]          idx;
  logic                found;
  logic [ADDR_W-1:0]   addr_sel;
  logic [WIDTH:0]      wdata_sel;
  logic                we_sel;
  logic                oor;

  // Scan from the requester after the last winner, wrapping modulo 4.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = 2'(32'(last_q) + k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pick == 2'(i)) begin
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*(WIDTH+1) +: WIDTH+1];
        we_sel    = we[i];
      end
    end
    oor = 32'(addr_sel) >= MEM_DEPTH;
  end

  // Outputs are computed one cycle ahead so each state's pulses appear registered.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    err_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = ISSUE;
          win_d       = pick;
          last_d      = pick;
          gnt_d       = 4'b0001 << pick;
          mem_addr_d  = addr_sel;
          mem_wdata_d = wdata_sel;
          if (oor) begin
            err_d = 4'b0001 << pick;
          end else begin
            mem_en_d = 1'b1;
            mem_we_d = we_sel;
          end
        end
      end
      ISSUE: begin
        state_d = (mem_en_q && !mem_we_q) ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        state_d  = IDLE;
        rvalid_d = 4'b0001 << win_q;
        rdata_d  = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      win_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model and a shadow memory.
module tb_data_mem_arbiter;
  localparam int unsigned WIDTH     = 15;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned MEM_DEPTH = 400;
  localparam int unsigned DW        = WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           req, we;
  logic [4*ADDR_W-1:0]  addr;
  logic [4*DW-1:0]      wdata;
  logic [3:0]           gnt, rvalid, err;
  logic [WIDTH:0]       rdata, mem_wdata;
  logic [WIDTH:0]       mem_rdata = '0;
  logic                 busy, mem_en, mem_we;
  logic [ADDR_W-1:0]    mem_addr;

  logic [WIDTH:0]       phys_mem [0:511] = '{default: '0};
  logic [WIDTH:0]       ref_mem  [0:511];
  int                   n_cmp = 0;
  int                   n_bad = 0;
  int                   m_last;
  logic [WIDTH:0]       m_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= phys_mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input int a, input logic [WIDTH:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int unsigned s = $urandom_range(0, 9);
    if (s == 0) return ADDR_W'($urandom_range(400, 511));
    if (s == 1) return ADDR_W'(399);
    if (s == 2) return ADDR_W'(400);
    return ADDR_W'($urandom_range(0, 31));
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    n_cmp++;
    if ({gnt, rvalid, err, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b rvalid=%b err=%b busy=%b en=%b we=%b addr=%0d wd=%h rd=%h exp all zero",
               gnt, rvalid, err, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata);
    end
    rst = 1'b0; m_last = 3; m_rdata = '0;
    tick();
    n_cmp++;
    if ({gnt, busy} !== 5'b0) begin
      n_bad++; $display("FAIL reset_idle: got gnt=%b busy=%b exp 0000/0", gnt, busy);
    end
  endtask

  task automatic test_write_read();
    logic [WIDTH:0] d = 16'hAAAA;
    set_req(0, 1'b1, 0, d);
    tick();
    n_cmp++;
    if ({gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0001, 1'b1, 1'b1, 9'd0, d}) begin
      n_bad++; $display("FAIL wr_issue: got gnt=%b en=%b we=%b addr=%0d wd=%h exp 0001/1/1/0/aaaa",
                        gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    req = '0;
    tick();
    n_cmp++;
    if ({gnt, busy, mem_en} !== 6'b0) begin
      n_bad++; $display("FAIL wr_done: got gnt=%b busy=%b en=%b exp 0000/0/0", gnt, busy, mem_en);
    end
    ref_mem[0] = d; m_last = 0;
    set_req(0, 1'b0, 0, '0);
    tick();
    n_cmp++;
    if ({gnt, mem_en, mem_we, mem_addr} !== {4'b0001, 1'b1, 1'b0, 9'd0}) begin
      n_bad++; $display("FAIL rd_issue: got gnt=%b en=%b we=%b addr=%0d exp 0001/1/0/0", gnt, mem_en, mem_we, mem_addr);
    end
    req = '0;
    tick();
    n_cmp++;
    if ({rvalid, busy} !== 5'b00001) begin
      n_bad++; $display("FAIL rd_wait: got rvalid=%b busy=%b exp 0000/1", rvalid, busy);
    end
    tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0001, 16'hAAAA}) begin
      n_bad++; $display("FAIL rd_data: got rvalid=%b rdata=%h exp 0001/aaaa", rvalid, rdata);
    end
    m_rdata = 16'hAAAA;
    tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0000, 16'hAAAA}) begin
      n_bad++; $display("FAIL rd_hold: got rvalid=%b rdata=%h exp 0000/aaaa", rvalid, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    test_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10 + i, DW'($urandom));
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = 4'b0001 << (k % 4);
      n_cmp++;
      if ({gnt, mem_addr, mem_wdata} !== {exp_g, ADDR_W'(10 + k % 4), wdata[(k % 4)*DW +: DW]}) begin
        n_bad++; $display("FAIL rr_grant[%0d]: got gnt=%b addr=%0d wd=%h exp %b/%0d/%h",
                          k, gnt, mem_addr, mem_wdata, exp_g, 10 + k % 4, wdata[(k % 4)*DW +: DW]);
      end
      ref_mem[10 + k % 4] = wdata[(k % 4)*DW +: DW];
      tick();
      n_cmp++;
      if ({gnt, busy} !== 5'b0) begin
        n_bad++; $display("FAIL rr_gap[%0d]: got gnt=%b busy=%b exp 0000/0", k, gnt, busy);
      end
    end
    req = '0; m_last = 3;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [WIDTH:0] d = DW'($urandom);
    req = '0;
    set_req(2, 1'b0, 400, '0);
    tick();
    n_cmp++;
    if ({gnt, err, mem_en} !== {4'b0100, 4'b0100, 1'b0}) begin
      n_bad++; $display("FAIL oor_issue: got gnt=%b err=%b en=%b exp 0100/0100/0", gnt, err, mem_en);
    end
    req = '0; m_last = 2;
    tick();
    n_cmp++;
    if ({gnt, err, busy, rvalid} !== 13'b0) begin
      n_bad++; $display("FAIL oor_end: got gnt=%b err=%b busy=%b rvalid=%b exp all 0", gnt, err, busy, rvalid);
    end
    tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0000, m_rdata}) begin
      n_bad++; $display("FAIL oor_norv: got rvalid=%b rdata=%h exp 0000/%h", rvalid, rdata, m_rdata);
    end
    set_req(2, 1'b1, 399, d);
    tick();
    n_cmp++;
    if ({gnt, err, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0100, 4'b0000, 1'b1, 1'b1, 9'd399, d}) begin
      n_bad++; $display("FAIL edge_wr: got gnt=%b err=%b en=%b we=%b addr=%0d wd=%h exp 0100/0000/1/1/399/%h",
                        gnt, err, mem_en, mem_we, mem_addr, mem_wdata, d);
    end
    req = '0; ref_mem[399] = d;
    tick();
    set_req(2, 1'b0, 399, '0);
    tick();
    req = '0;
    tick(); tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0100, d}) begin
      n_bad++; $display("FAIL edge_rd: got rvalid=%b rdata=%h exp 0100/%h", rvalid, rdata, d);
    end
    m_rdata = d;
  endtask

  task automatic test_reset_mid_read();
    test_reset();
    req = '0;
    set_req(0, 1'b0, 0, '0);
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++; $display("FAIL rst_pre_gnt: got %b exp 0001", gnt);
    end
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, rvalid, err, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      n_bad++; $display("FAIL rst_mid: got gnt=%b rvalid=%b err=%b busy=%b en=%b rd=%h exp all zero",
                        gnt, rvalid, err, busy, mem_en, rdata);
    end
    rst = 1'b0; m_last = 3; m_rdata = '0;
    tick();
    n_cmp++;
    if ({rvalid, busy} !== 5'b0) begin
      n_bad++; $display("FAIL rst_norv: got rvalid=%b busy=%b exp 0000/0", rvalid, busy);
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10 + i, '0);
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++; $display("FAIL rst_first_gnt: got %b exp 0001", gnt);
    end
    req = '0; m_last = 0;
    tick(); tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0001, ref_mem[10]}) begin
      n_bad++; $display("FAIL rst_after_rd: got rvalid=%b rdata=%h exp 0001/%h", rvalid, rdata, ref_mem[10]);
    end
    m_rdata = ref_mem[10];
  endtask

  task automatic test_simultaneous();
    logic [WIDTH:0] d0 = DW'($urandom);
    logic [WIDTH:0] d3 = DW'($urandom);
    test_reset();
    set_req(0, 1'b1, 5, d0);
    tick();
    req = '0; ref_mem[5] = d0; m_last = 0;
    tick();
    set_req(1, 1'b0, 5, '0);
    set_req(3, 1'b1, 20, d3);
    tick();
    n_cmp++;
    if ({gnt, mem_we, mem_addr} !== {4'b0010, 1'b0, 9'd5}) begin
      n_bad++; $display("FAIL sim_first: got gnt=%b we=%b addr=%0d exp 0010/0/5", gnt, mem_we, mem_addr);
    end
    req[1] = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++; $display("FAIL sim_wait: got gnt=%b exp 0000", gnt);
    end
    tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0010, d0}) begin
      n_bad++; $display("FAIL sim_rdata: got rvalid=%b rdata=%h exp 0010/%h", rvalid, rdata, d0);
    end
    tick();
    n_cmp++;
    if ({gnt, mem_we, mem_addr, mem_wdata} !== {4'b1000, 1'b1, 9'd20, d3}) begin
      n_bad++; $display("FAIL sim_second: got gnt=%b we=%b addr=%0d wd=%h exp 1000/1/20/%h",
                        gnt, mem_we, mem_addr, mem_wdata, d3);
    end
    req = '0; ref_mem[20] = d3; m_last = 3;
    tick();
    set_req(0, 1'b0, 20, '0);
    tick();
    req = '0; m_last = 0;
    tick(); tick();
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0001, d3}) begin
      n_bad++; $display("FAIL sim_readback: got rvalid=%b rdata=%h exp 0001/%h", rvalid, rdata, d3);
    end
    m_rdata = d3;
  endtask

  task automatic test_random();
    int unsigned    wait_cnt [4];
    logic [3:0]     r, oh;
    int             w;
    logic [ADDR_W-1:0] a;
    logic [WIDTH:0] d;
    logic           is_wr, oor;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    req = '0;
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), int'(rand_addr()), DW'($urandom));
      end
      r = req;
      tick();
      if (r == 4'b0000) begin
        n_cmp++;
        if ({gnt, busy} !== 5'b0) begin
          n_bad++; $display("FAIL rnd_idle[%0d]: got gnt=%b busy=%b exp 0000/0", it, gnt, busy);
        end
        continue;
      end
      w = -1;
      for (int k = 1; k <= 4; k++) if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
      m_last = w;
      oh    = 4'b0001 << w;
      a     = addr[w*ADDR_W +: ADDR_W];
      d     = wdata[w*DW +: DW];
      is_wr = we[w];
      oor   = 32'(a) >= MEM_DEPTH;
      n_cmp++;
      if ({gnt, busy} !== {oh, 1'b1}) begin
        n_bad++; $display("FAIL rnd_gnt[%0d]: got gnt=%b busy=%b exp %b/1", it, gnt, busy, oh);
      end
      n_cmp++;
      if (oor) begin
        if ({err, mem_en} !== {oh, 1'b0}) begin
          n_bad++; $display("FAIL rnd_err[%0d]: got err=%b en=%b exp %b/0", it, err, mem_en, oh);
        end
      end else if ({err, mem_en, mem_we, mem_addr} !== {4'b0000, 1'b1, is_wr, a} ||
                   (is_wr && mem_wdata !== d)) begin
        n_bad++; $display("FAIL rnd_acc[%0d]: got err=%b en=%b we=%b addr=%0d wd=%h exp 0000/1/%b/%0d/%h",
                          it, err, mem_en, mem_we, mem_addr, mem_wdata, is_wr, a, d);
      end
      n_cmp++;
      if (wait_cnt[w] > 3) begin
        n_bad++; $display("FAIL rnd_starve[%0d]: got %0d other grants while waiting exp <= 3", it, wait_cnt[w]);
      end
      wait_cnt[w] = 0;
      for (int i = 0; i < 4; i++) if (i != w && r[i]) wait_cnt[i]++;
      req[w] = 1'b0;
      tick();
      n_cmp++;
      if ({gnt, err, mem_en} !== 9'b0) begin
        n_bad++; $display("FAIL rnd_clr[%0d]: got gnt=%b err=%b en=%b exp 0000/0000/0", it, gnt, err, mem_en);
      end
      if (!oor && !is_wr) begin
        n_cmp++;
        if ({rvalid, busy} !== 5'b00001) begin
          n_bad++; $display("FAIL rnd_rdwait[%0d]: got rvalid=%b busy=%b exp 0000/1", it, rvalid, busy);
        end
        tick();
        n_cmp++;
        if ({rvalid, rdata, busy} !== {oh, ref_mem[a], 1'b0}) begin
          n_bad++; $display("FAIL rnd_rd[%0d]: got rvalid=%b rdata=%h busy=%b exp %b/%h/0",
                            it, rvalid, rdata, busy, oh, ref_mem[a]);
        end
        m_rdata = ref_mem[a];
      end else begin
        n_cmp++;
        if ({rvalid, busy, rdata} !== {4'b0000, 1'b0, m_rdata}) begin
          n_bad++; $display("FAIL rnd_nord[%0d]: got rvalid=%b busy=%b rdata=%h exp 0000/0/%h",
                            it, rvalid, busy, rdata, m_rdata);
        end
        if (!oor) ref_mem[a] = d;
      end
    end
    req = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_reset_mid_read();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
